// File: rtl/rip_csr_trap_pkg.sv
// Shared constants and types for the RIP machine-mode CSR / trap block.
//   - CSR addresses (MTVEC, MEPC, MCAUSE, MCYCLE, MCYCLEH)
//   - trap cause codes
//   - csr_op_e : CSR instruction write operation
//   - state_e  : trap sequencer states
//   - csr_apply: computes the new CSR value for a write operation
package rip_const;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] MCYCLE     = 12'hB00;
  localparam logic [11:0] MCYCLEH    = 12'hB80;

  localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
  localparam logic [31:0] CAUSE_ECALL        = 32'd11;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RW   = 2'b01,
    RS   = 2'b10,
    RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  function automatic logic [31:0] csr_apply(input csr_op_e     op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      RW:      return wdata;
      RS:      return old_val | wdata;
      RC:      return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/rip_csr_trap_counter.sv
// 64-bit free-running cycle counter with half-word writes.
// A write to either half replaces that half and suppresses the increment
// for that cycle. Wraps from 2^64-1 to 0.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   wr_lo_i, wr_hi_i write enable for bits [31:0] / [63:32]
//   wdata_i          write data for the selected half
//   count_o          current counter value
module rip_csr_counter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (wr_lo_i) begin
      count_q[31:0] <= wdata_i;
    end else if (wr_hi_i) begin
      count_q[63:32] <= wdata_i;
    end else begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/rip_csr_trap.sv
// Machine-mode CSR file and trap sequencer for the RIP core.
// Executes csrrw/csrrs/csrrc on mtvec/mepc/mcause, takes ecall and
// illegal-instruction traps, executes mret, and issues a registered
// one-cycle PC redirect to fetch followed by a flush window during which
// all requests are ignored.
// Optional feature macro: RIP_CSR_MCYCLE_EN adds a 64-bit mcycle counter
// readable/writable at 0xB00 (low) / 0xB80 (high).
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   csr_en/op/addr/wdata      CSR instruction request
//   csr_rdata                 combinational old value of addressed CSR
//   inst_pc                   PC of the presented instruction
//   ecall, illegal, mret      trap / return requests
//   redirect_valid/pc         registered redirect to fetch
//   busy                      high in REDIRECT/FLUSH, upstream squashes
module rip_csr_trap
  import rip_const::*;
#(
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic [31:0] inst_pc,
  input  logic        ecall,
  input  logic        illegal,
  input  logic        mret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  state_e      state_q;
  logic [3:0]  flush_cnt_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q, redirect_pc_q;
  logic        redirect_valid_q, busy_q;

  csr_op_e     op;
  logic        addr_known;
  logic        take_illegal, take_trap, csr_wr;
  logic [31:0] wval_d;

`ifdef RIP_CSR_MCYCLE_EN
  logic [63:0] mcycle;

  rip_csr_counter u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .wr_lo_i (csr_wr && (csr_addr == MCYCLE)),
    .wr_hi_i (csr_wr && (csr_addr == MCYCLEH)),
    .wdata_i (wval_d),
    .count_o (mcycle)
  );
`endif

  assign op = csr_op_e'(csr_op);

  // Read mux doubles as the address decoder for illegal-access detection.
  always_comb begin
    csr_rdata  = '0;
    addr_known = 1'b1;
    case (csr_addr)
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
`ifdef RIP_CSR_MCYCLE_EN
      MCYCLE:     csr_rdata = mcycle[31:0];
      MCYCLEH:    csr_rdata = mcycle[63:32];
`endif
      default:    addr_known = 1'b0;
    endcase
  end

  assign take_illegal = illegal | (csr_en & ~addr_known);
  assign take_trap    = take_illegal | ecall;
  assign csr_wr       = (state_q == IDLE) & csr_en & (op != NONE) & ~take_trap & ~mret;
  assign wval_d       = csr_apply(op, csr_rdata, csr_wdata);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= IDLE;
      flush_cnt_q      <= '0;
      mtvec_q          <= {RESET_MTVEC[31:2], 2'b00};
      mepc_q           <= '0;
      mcause_q         <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_trap) begin
            mepc_q           <= {inst_pc[31:2], 2'b00};
            mcause_q         <= take_illegal ? CAUSE_ILLEGAL_INST : CAUSE_ECALL;
            redirect_pc_q    <= mtvec_q;
            redirect_valid_q <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= REDIRECT;
          end else if (mret) begin
            redirect_pc_q    <= mepc_q;
            redirect_valid_q <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= REDIRECT;
          end else if (csr_wr) begin
            case (csr_addr)
              CSR_MTVEC:  mtvec_q  <= {wval_d[31:2], 2'b00};
              CSR_MEPC:   mepc_q   <= {wval_d[31:2], 2'b00};
              CSR_MCAUSE: mcause_q <= wval_d;
              default:    ;
            endcase
          end
        end
        REDIRECT: begin
          redirect_valid_q <= 1'b0;
          if (FLUSH_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            flush_cnt_q <= 4'(FLUSH_CYCLES);
            state_q     <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == 4'd1) begin
            flush_cnt_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: doc/rip_csr_trap.md
Name: rip_csr_trap

Overview:
- Machine-mode CSR file and trap sequencer for the RIP core.
- Sits beside execute and is consumed by fetch:
  - executes csrrw/csrrs/csrrc on MTVEC (0x305), MEPC (0x341) and MCAUSE (0x342);
  - takes ecall and illegal-instruction traps;
  - executes mret;
  - emits a registered PC redirect to fetch, then ignores requests while the wrong path drains.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.
- FLUSH_CYCLES, 2, cycles after a redirect during which all requests are ignored (range 0..15).

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  01 RW, 10 RS (set bits), 11 RC (clear bits), 00 no write
- csr_addr  in  12  CSR address
- csr_wdata  in  32  rs1/zimm operand
- csr_rdata  out  32  combinational old value of addressed CSR (0 if unknown)
- inst_pc  in  32  PC of the instruction currently presented
- ecall  in  1  ecall executing
- illegal  in  1  decoder flagged illegal instruction
- mret  in  1  mret executing
- redirect_valid  out  1  registered one-cycle redirect pulse to fetch
- redirect_pc  out  32  registered redirect target
- busy  out  1  high in REDIRECT/FLUSH; upstream must squash

Behaviour:
- Reset (async, rstn=0):
  - mtvec=RESET_MTVEC&~3; mepc=0; mcause=0.
  - redirect_valid=0, redirect_pc=0, busy=0, state=IDLE, flush counter=0.
- Illegal CSR access: csr_en=1 with an address outside {0x305, 0x341, 0x342} (plus the counter addresses when enabled) is an illegal-instruction trap. No write occurs.
- Request priority, evaluated only in IDLE: illegal (incl. illegal CSR access) > ecall > mret > CSR write.
- Trap (illegal or ecall) in cycle N:
  - mepc<=inst_pc&~3.
  - mcause<=2 for illegal, 11 for ecall.
  - A CSR write in the same cycle is suppressed.
  - Cycle N+1: redirect_valid=1, redirect_pc=mtvec as held in cycle N.
- mret in cycle N: cycle N+1 redirect_valid=1, redirect_pc=mepc as held in cycle N. No CSR changes.
- CSR write new value:
  - RW: wdata.
  - RS: old|wdata.
  - RC: old&~wdata.
  - op=00: read only, no write.
- Write rules:
  - The write is visible on csr_rdata from cycle N+1. No forwarding.
  - mtvec and mepc bits[1:0] are forced to 0 on write (mtvec is direct mode only).
  - mcause is fully writable.
- State machine:
  - IDLE: on trap or mret -> REDIRECT.
  - REDIRECT (1 cycle, redirect_valid=1, busy=1):
    - FLUSH_CYCLES=0 -> IDLE.
    - otherwise load counter=FLUSH_CYCLES -> FLUSH.
  - FLUSH (busy=1): decrement each cycle; when counter==1 -> IDLE.
  - All inputs are ignored in REDIRECT and FLUSH. csr_rdata stays combinational in every state.
- redirect_valid is exactly one cycle wide. redirect_pc holds its value until the next redirect.
- Simultaneous ecall+illegal: cause=2. Simultaneous mret+illegal: trap, no mret.
- Reset mid-FLUSH returns to IDLE with all reset values immediately.

Optional Feature:
- Macro: RIP_CSR_MCYCLE_EN.
- Defined:
  - 64-bit mcycle counter, increments every cycle out of reset and wraps at 2^64-1 -> 0.
  - Readable at 0xB00 (low word) and 0xB80 (high word).
  - A write to either address replaces that half, and the counter skips its increment that cycle.
  - Reset value 0.
- Undefined: 0xB00/0xB80 are unknown addresses and raise an illegal trap.

Decomposition:
- Shared package rip_const gains:
  - MCYCLE=12'hB00, MCYCLEH=12'hB80;
  - csr_op_e enum (NONE, RW, RS, RC);
  - state enum (IDLE, REDIRECT, FLUSH).
- It keeps CAUSE_ILLEGAL_INST=2 and CAUSE_ECALL=11.
- Sub-module rip_csr_counter (64-bit counter with half-word writes) is instantiated only under RIP_CSR_MCYCLE_EN.

Test Plan:
1. Reset with RESET_MTVEC=32'h0000_0103 -> mtvec reads 0x100, mepc 0, mcause 0, redirect_valid 0, busy 0.
2. csrrw 0x305 wdata 0x8000_0007, then csrrs 0x342 wdata 0xF0, then csrrc 0x342 wdata 0x30:
   - mtvec reads 0x8000_0004 next cycle;
   - mcause reads 0xC0 after both writes.
3. ecall at inst_pc 0x1236 with mtvec 0x200 -> next cycle redirect_valid=1, redirect_pc=0x200; mepc=0x1234, mcause=11; busy for 1+FLUSH_CYCLES=3 cycles. An ecall applied during busy is ignored.
4. csr_en with csr_addr 0x7C0 and RW wdata 0xFFFF_FFFF -> mcause=2, no register changed, redirect to mtvec.
5. mret with mepc 0x4000 asserted in the same cycle as illegal -> trap wins: mcause=2, redirect_pc=mtvec, mepc=inst_pc.
6. Counter tests:
   - RIP_CSR_MCYCLE_EN defined: write 0xB00=0xFFFF_FFFF and 0xB80=0xFFFF_FFFF, wait 1 cycle -> reads 0/0 (wrap).
   - RIP_CSR_MCYCLE_EN undefined: the same access traps with cause 2.
